// File: rtl/issue_execute_fifo_pkg.sv
// Shared pack types between issue, execute and commit, plus FIFO pointer helpers.
// Each execute unit's issue queue is built from these types.
package issue_execute_fifo_pkg;

    localparam int ROB_ID_W = 6;
    localparam int REG_W    = 5;
    localparam int OPC_W    = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_SLL = 4'h7
    } exec_op_e;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        exec_op_e            op;
        logic [REG_W-1:0]    rd;
        logic [DATA_W-1:0]   op_a;
        logic [DATA_W-1:0]   op_b;
    } issue_execute_pack_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

    // Decides whether a flush is requested this cycle.
    function automatic logic flush_requested(input commit_feedback_pack_t fb);
        return fb.enable & fb.flush;
    endfunction

endpackage

// File: rtl/issue_execute_fifo.sv
// Queue between issue and one execute unit: first-word-fall-through head,
// single-cycle pop, commit flush. All outputs come from registers only.
module issue_execute_fifo
    import issue_execute_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  issue_execute_pack_t   data_in,
    input  logic                  push,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output issue_execute_pack_t   data_out,
    output logic                  data_out_valid,
    input  logic                  pop,
    input  commit_feedback_pack_t commit_feedback_pack
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]    rptr;
    logic [PTR_W-1:0]    wptr;
    logic [CNT_W-1:0]    occ;
    issue_execute_pack_t storage [DEPTH];

    logic flush_req;
    logic push_ok;
    logic pop_ok;

    assign flush_req = flush_requested(commit_feedback_pack);

    assign full           = (occ == CNT_W'(DEPTH));
    assign data_out_valid = (occ != '0);
    assign data_out       = storage[rptr];
    assign count          = occ;

    // Room is judged on registered occupancy; a same-cycle pop never frees a slot.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & data_out_valid;

    always_ff @(posedge clk) begin
        if (rst || flush_req) begin
            rptr <= '0;
            wptr <= '0;
            occ  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            occ <= occ + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; validity is tracked by occ alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush_req && push_ok) begin
            storage[wptr] <= data_in;
        end
    end

    always @(posedge clk) begin
        if (!rst && !flush_req) begin
            assert (!(push && full))
                else $warning("issue_execute_fifo: push dropped, queue has no room");
            assert (!(pop && !data_out_valid))
                else $warning("issue_execute_fifo: pop ignored, queue is empty");
        end
    end

endmodule
